osd_spi_rx: RTL and testbench

- Single-clock SPI slave that decodes the io-controller OSD command stream in the pixel clock domain.
- Directly upstream of the OSD overlay stage.
- Drives a byte-wide write port into the OSD character buffer and the OSD enable flag.
- Replaces the sck-clocked receive logic, so the whole OSD path runs on pclk.

---
 rtl/osd_pkg.sv | 9 +
 rtl/osd_sync.sv | 21 ++
 rtl/osd_spi_rx.sv | 129 ++++++++++++
 tb/tb_osd_spi_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// osd_pkg: shared constants and state type for the OSD SPI receive path.
// Holds command opcodes, buffer geometry and the receiver state enum.
package osd_pkg;
    localparam logic [4:0] OSD_CMD_WRITE  = 5'b00100;
    localparam logic [6:0] OSD_CMD_ENABLE = 7'b0100000;
    localparam int         OSD_LINES      = 8;
    localparam int         OSD_LINE_BYTES = 256;
    typedef enum logic [1:0] {IDLE, CMD, PAYLOAD, DISCARD} osd_state_e;
endpackage

// File: rtl/osd_sync.sv
// osd_sync: N-stage single-bit synchroniser into the pclk domain.
// Ports: pclk, reset_n (sync active-low, clears the chain), d (async in), q (synced out).
module osd_sync #(
    parameter int N = 2
) (
    input  logic pclk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] ff_q, ff_d;

    always_comb ff_d = {ff_q[N-2:0], d};

    always_ff @(posedge pclk) begin
        if (!reset_n) ff_q <= '0;
        else          ff_q <= ff_d;
    end

    assign q = ff_q[N-1];
endmodule

// File: rtl/osd_spi_rx.sv
// osd_spi_rx: pclk-domain SPI slave decoding the OSD command stream.
// Ports: pclk, reset_n (sync active-low); sck/ss/sdi asynchronous SPI pins;
// osd_enable (OSD visible flag); wr_en/wr_addr/wr_data character-buffer write
// port; busy (high while a transaction is open).
// Build option OSD_SPI_DECIMATE_EN: only odd payload bytes are written, at
// half the byte pointer, for the half-resolution buffer.
module osd_spi_rx
    import osd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = $clog2(OSD_LINES * OSD_LINE_BYTES)
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              ss,
    input  logic              sdi,
    output logic              osd_enable,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);
    logic sck_s, ss_s, sdi_s;
    logic sck_rise, ss_fall, byte_done;
    logic [7:0] byte_v;

    osd_sync #(.N(SYNC_STAGES)) u_sync_sck (.pclk(pclk), .reset_n(reset_n), .d(sck), .q(sck_s));
    osd_sync #(.N(SYNC_STAGES)) u_sync_ss  (.pclk(pclk), .reset_n(reset_n), .d(ss),  .q(ss_s));
    osd_sync #(.N(SYNC_STAGES)) u_sync_sdi (.pclk(pclk), .reset_n(reset_n), .d(sdi), .q(sdi_s));

    osd_state_e        state_q, state_d;
    logic              sck_prev_q, sck_prev_d;
    logic              ss_prev_q, ss_prev_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [6:0]        sr_q, sr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              osd_enable_q, osd_enable_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    always_comb begin
        sck_rise     = sck_s & ~sck_prev_q;
        // ss_prev resets low, so a select already held low across reset is not a fall
        ss_fall      = ss_prev_q & ~ss_s;
        byte_done    = sck_rise && cnt_q == 3'd7;
        // sr holds only the 7 earlier bits; the 8th comes straight from the synced pin
        byte_v       = {sr_q, sdi_s};
        sck_prev_d   = sck_s;
        ss_prev_d    = ss_s;
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sck_rise ? byte_v[6:0] : sr_q;
        ptr_d        = ptr_q;
        osd_enable_d = osd_enable_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (state_q != IDLE && sck_rise) cnt_d = cnt_q + 3'd1;
        if (ss_s && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = 3'd0;
                    if (ss_fall) state_d = CMD;
                end
                CMD: begin
                    if (byte_done) begin
                        state_d = byte_v[7:3] == OSD_CMD_WRITE ? PAYLOAD : DISCARD;
                        if (byte_v[7:3] == OSD_CMD_WRITE) ptr_d = ADDR_W'({byte_v[2:0], 8'h00});
                        if (byte_v[7:1] == OSD_CMD_ENABLE) osd_enable_d = byte_v[0];
                    end
                end
                PAYLOAD: begin
                    if (byte_done) begin
                        ptr_d = ptr_q + ADDR_W'(1);
`ifdef OSD_SPI_DECIMATE_EN
                        wr_en_d = ptr_q[0];
                        if (ptr_q[0]) begin
                            wr_addr_d = {1'b0, ptr_q[ADDR_W-1:1]};
                            wr_data_d = byte_v;
                        end
`else
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = byte_v;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sck_prev_q   <= 1'b0;
            ss_prev_q    <= 1'b0;
            cnt_q        <= '0;
            sr_q         <= '0;
            ptr_q        <= '0;
            osd_enable_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            sck_prev_q   <= sck_prev_d;
            ss_prev_q    <= ss_prev_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            ptr_q        <= ptr_d;
            osd_enable_q <= osd_enable_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign osd_enable = osd_enable_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_osd_spi_rx.sv
// tb_osd_spi_rx: directed self-checking bench for osd_spi_rx.
module tb_osd_spi_rx;
    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck = 1'b0;
    logic        ss = 1'b1;
    logic        sdi = 1'b0;
    logic        osd_enable, wr_en, busy;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int edge_cyc = 0;

    logic [10:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    int          wq_cyc[$];

    osd_spi_rx dut (
        .pclk(pclk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
        .osd_enable(osd_enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic send_bit(input logic b);
        sck = 1'b0;
        sdi = b;
        repeat (2) @(negedge pclk);
        sck = 1'b1;
        edge_cyc = cyc;
        repeat (2) @(negedge pclk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic start_txn();
        @(negedge pclk);
        ss = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic end_txn();
        sck = 1'b0;
        repeat (2) @(negedge pclk);
        ss = 1'b1;
        repeat (8) @(negedge pclk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge pclk);
        checks++; if (osd_enable !== 1'b0) begin errors++; $display("FAIL reset_osd_enable got %b exp 0", osd_enable); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (wr_addr !== 11'h000) begin errors++; $display("FAIL reset_wr_addr got %h exp 000", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h exp 00", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        reset_n = 1'b1;
        repeat (4) @(negedge pclk);
    endtask

    task automatic test_enable();
        clear_q();
        start_txn();
        send_byte(8'h41);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enable_busy got %b exp 1", busy); end
        end_txn();
        checks++; if (osd_enable !== 1'b1) begin errors++; $display("FAIL enable_on got %b exp 1", osd_enable); end
        start_txn();
        send_byte(8'h40);
        end_txn();
        checks++; if (osd_enable !== 1'b0) begin errors++; $display("FAIL enable_off got %b exp 0", osd_enable); end
        checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL enable_no_write got %0d exp 0", wq_addr.size()); end
    endtask

    task automatic test_write();
        clear_q();
        start_txn();
        send_byte(8'h23);
        send_byte(8'hAA);
        send_byte(8'h55);
        end_txn();
`ifdef OSD_SPI_DECIMATE_EN
        checks++; if (wq_addr.size() !== 1) begin errors++; $display("FAIL write_count got %0d exp 1", wq_addr.size()); end
        else begin
            checks++; if (wq_addr[0] !== 11'h180 || wq_data[0] !== 8'h55) begin errors++; $display("FAIL write0 got %h/%h exp 180/55", wq_addr[0], wq_data[0]); end
        end
`else
        checks++; if (wq_addr.size() !== 2) begin errors++; $display("FAIL write_count got %0d exp 2", wq_addr.size()); end
        else begin
            checks++; if (wq_addr[0] !== 11'h300 || wq_data[0] !== 8'hAA) begin errors++; $display("FAIL write0 got %h/%h exp 300/aa", wq_addr[0], wq_data[0]); end
            checks++; if (wq_addr[1] !== 11'h301 || wq_data[1] !== 8'h55) begin errors++; $display("FAIL write1 got %h/%h exp 301/55", wq_addr[1], wq_data[1]); end
        end
`endif
    endtask

    task automatic test_wrap();
        int exp_n;
        logic [10:0] exp_last;
`ifdef OSD_SPI_DECIMATE_EN
        exp_n = 128;
        exp_last = 11'h3FF;
`else
        exp_n = 257;
        exp_last = 11'h000;
`endif
        clear_q();
        start_txn();
        send_byte(8'h27);
        for (int i = 0; i < 257; i++) send_byte(8'h01);
        end_txn();
        checks++; if (wq_addr.size() !== exp_n) begin errors++; $display("FAIL wrap_count got %0d exp %0d", wq_addr.size(), exp_n); end
        else begin
            checks++; if (wq_addr[exp_n-1] !== exp_last || wq_data[exp_n-1] !== 8'h01) begin errors++; $display("FAIL wrap_last got %h/%h exp %h/01", wq_addr[exp_n-1], wq_data[exp_n-1], exp_last); end
        end
    endtask

    task automatic test_partial();
        clear_q();
        start_txn();
        send_byte(8'h20);
        send_byte(8'h5A);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        sck = 1'b0;
        repeat (4) @(negedge pclk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy_open got %b exp 1", busy); end
        ss = 1'b1;
        repeat (3) @(negedge pclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy_drop got %b exp 0", busy); end
        repeat (6) @(negedge pclk);
`ifdef OSD_SPI_DECIMATE_EN
        checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL partial_count got %0d exp 0", wq_addr.size()); end
`else
        checks++; if (wq_addr.size() !== 1) begin errors++; $display("FAIL partial_count got %0d exp 1", wq_addr.size()); end
        else begin
            checks++; if (wq_addr[0] !== 11'h000 || wq_data[0] !== 8'h5A) begin errors++; $display("FAIL partial_write got %h/%h exp 000/5a", wq_addr[0], wq_data[0]); end
        end
`endif
    endtask

    task automatic test_discard();
        start_txn();
        send_byte(8'h41);
        end_txn();
        clear_q();
        start_txn();
        send_byte(8'h99);
        send_byte(8'h12);
        end_txn();
        start_txn();
        send_byte(8'h12);
        send_byte(8'h34);
        end_txn();
        checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL discard_no_write got %0d exp 0", wq_addr.size()); end
        checks++; if (osd_enable !== 1'b1) begin errors++; $display("FAIL discard_enable got %b exp 1", osd_enable); end
    endtask

    task automatic test_reset_mid();
        clear_q();
        start_txn();
        send_byte(8'h20);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset_n = 1'b0;
        @(negedge pclk);
        checks++; if (osd_enable !== 1'b0) begin errors++; $display("FAIL rstmid_osd_enable got %b exp 0", osd_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (wr_data !== 8'h00 || wr_addr !== 11'h000 || wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr got %b/%h/%h exp 0/000/00", wr_en, wr_addr, wr_data); end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_byte(8'hC3);
        send_byte(8'h3C);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_ignored_busy got %b exp 0", busy); end
        end_txn();
        checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL rstmid_no_write got %0d exp 0", wq_addr.size()); end
    endtask

    task automatic test_latency();
        logic [7:0] pay[8];
        int         edges[8];
        int         k;
        foreach (pay[i]) pay[i] = 8'($urandom);
        clear_q();
        start_txn();
        send_byte(8'h20);
        for (int i = 0; i < 8; i++) begin
            send_byte(pay[i]);
            edges[i] = edge_cyc;
        end
        end_txn();
        k = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef OSD_SPI_DECIMATE_EN
            if (i % 2 == 1) begin
                checks++;
                if (k >= wq_addr.size()) begin errors++; $display("FAIL lat_missing byte %0d got none exp write", i); end
                else if (wq_addr[k] !== 11'(i / 2) || wq_data[k] !== pay[i] || wq_cyc[k] - edges[i] !== 3) begin
                    errors++; $display("FAIL lat_byte%0d got %h/%h lat %0d exp %h/%h lat 3", i, wq_addr[k], wq_data[k], wq_cyc[k] - edges[i], 11'(i / 2), pay[i]);
                end
                k++;
            end
`else
            checks++;
            if (k >= wq_addr.size()) begin errors++; $display("FAIL lat_missing byte %0d got none exp write", i); end
            else if (wq_addr[k] !== 11'(i) || wq_data[k] !== pay[i] || wq_cyc[k] - edges[i] !== 3) begin
                errors++; $display("FAIL lat_byte%0d got %h/%h lat %0d exp %h/%h lat 3", i, wq_addr[k], wq_data[k], wq_cyc[k] - edges[i], 11'(i), pay[i]);
            end
            k++;
`endif
        end
        checks++; if (wq_addr.size() !== k) begin errors++; $display("FAIL lat_count got %0d exp %0d", wq_addr.size(), k); end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_write();
        test_wrap();
        test_partial();
        test_discard();
        test_reset_mid();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
